// File: rtl/ram_burst_ctrl_if.sv
// ============================================================================
// Module      : ram_burst_ctrl_if
// Description : Control, stream and RAM-pin bundle for the burst controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ram_burst_ctrl_if #(
  parameter int DW = 8,
  parameter int AW = 4
);
  logic          start_wr;
  logic          start_rd;
  logic [AW-1:0] base_addr;
  logic [AW:0]   burst_len;

  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_din;
  logic          ram_wr_en;
  logic [DW-1:0] ram_dout;

  logic          busy;
  logic          done;

  // Controller side
  modport slave (
    input  start_wr, start_rd, base_addr, burst_len,
    input  s_valid, s_data, m_ready, ram_dout,
    output s_ready, m_valid, m_data,
    output ram_add, ram_din, ram_wr_en,
    output busy, done
  );

  // Requester / stream peer / RAM side
  modport master (
    output start_wr, start_rd, base_addr, burst_len,
    output s_valid, s_data, m_ready, ram_dout,
    input  s_ready, m_valid, m_data,
    input  ram_add, ram_din, ram_wr_en,
    input  busy, done
  );
endinterface

`default_nettype wire

// File: rtl/ram_burst_ctrl.sv
// ============================================================================
// Module      : ram_burst_ctrl
// Description : Write/read burst sequencer driving a single-port async-read RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_burst_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  ram_burst_ctrl_if.slave   bus
);

  localparam logic [AW:0] c_depth = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_m_data;
  logic          r_m_valid;

  logic          w_len_ok;
  logic          w_load;
  logic          w_wr_beat;
  logic          w_rd_issue;
  logic          w_rd_last;

  // Lengths of zero or beyond the RAM depth are silently dropped.
  assign w_len_ok = (bus.burst_len != '0) && (bus.burst_len <= c_depth);

  assign bus.m_valid = r_m_valid;
  assign bus.m_data  = r_m_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_load        = 1'b0;
    w_wr_beat     = 1'b0;
    w_rd_issue    = 1'b0;
    w_rd_last     = 1'b0;
    bus.s_ready   = 1'b0;
    bus.ram_wr_en = 1'b0;
    bus.ram_add   = r_ptr;
    bus.ram_din   = bus.s_data;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        bus.busy = 1'b0;
        if (w_len_ok && (bus.start_wr || bus.start_rd)) begin
          w_load      = 1'b1;
          w_state_nxt = bus.start_wr ? ST_WRITE : ST_READ;
        end
      end

      ST_WRITE: begin
        bus.s_ready   = 1'b1;
        bus.ram_wr_en = bus.s_valid;
        if (bus.s_valid) begin
          w_wr_beat = 1'b1;
          if (r_count == (AW+1)'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_READ: begin
        // Refill the output register whenever it is empty or being drained.
        if ((r_count != '0) && (!r_m_valid || bus.m_ready)) begin
          w_rd_issue = 1'b1;
        end
        if ((r_count == '0) && r_m_valid && bus.m_ready) begin
          w_rd_last   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        bus.done    = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      r_count   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_ptr   <= bus.base_addr;
        r_count <= bus.burst_len;
      end
      // Pointer wraps naturally at the RAM depth.
      if (w_wr_beat || w_rd_issue) begin
        r_ptr   <= r_ptr + 1'b1;
        r_count <= r_count - 1'b1;
      end
      if (w_rd_issue) begin
        r_m_data  <= bus.ram_dout;
        r_m_valid <= 1'b1;
      end else if (w_rd_last) begin
        r_m_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_burst_ctrl.sv
// ============================================================================
// Module      : tb_ram_burst_ctrl
// Description : Scoreboard bench for ram_burst_ctrl with a behavioural RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_burst_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic ram_init = 1'b1;
  int   rdy_mode = 1;

  always #5 clk = ~clk;

  ram_burst_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  ram_burst_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Environment RAM: async read, registered write.
  logic [7:0] ram [DEPTH];
  assign bus.ram_dout = ram[bus.ram_add];
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i * 7 + 3);
    end else if (bus.ram_wr_en) begin
      ram[bus.ram_add] <= bus.ram_din;
    end
  end

  // Reference model and scoreboard
  logic [7:0]  ref_mem [DEPTH];
  logic [11:0] wq [$];
  logic [7:0]  rq [$];
  logic [7:0]  wdata_q [$];
  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.m_ready = 1'($urandom_range(0, 1));
      1:       bus.m_ready = 1'b1;
      default: bus.m_ready = ~bus.m_ready;
    endcase
  end

  logic [11:0] mon_w;
  logic [7:0]  mon_r;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.ram_wr_en) begin
        if (wq.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_w = wq.pop_front();
          chk("wr_addr", 32'(bus.ram_add), 32'(mon_w[11:8]));
          chk("wr_data", 32'(bus.ram_din), 32'(mon_w[7:0]));
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (rq.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          mon_r = rq.pop_front();
          chk("rd_data", 32'(bus.m_data), 32'(mon_r));
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.m_valid), 1);
        chk("stall_data", 32'(bus.m_data), 32'(prev_data));
      end
      if (bus.done) done_seen++;
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic wait_done(input string nm);
    int n = 0;
    while (!bus.done && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(bus.done), 1);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_after"}, {bus.busy, bus.done, bus.m_valid, bus.s_ready}, 0);
  endtask

  task automatic do_write(input logic [3:0] base, input logic [4:0] len,
                          input int gap, input bit both, input bit poke);
    logic [7:0] d;
    logic [3:0] a;
    int g;
    @(posedge clk); #1;
    bus.start_wr = 1'b1; bus.start_rd = both;
    bus.base_addr = base; bus.burst_len = len;
    @(posedge clk); #1;
    bus.start_wr = 1'b0; bus.start_rd = 1'b0;
    bus.base_addr = 4'($urandom); bus.burst_len = 5'($urandom);
    chk("wr_entered", {bus.busy, bus.s_ready}, 2'b11);
    exp_done++;
    for (int i = 0; i < int'(len); i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin @(posedge clk); #1; end
      d = (wdata_q.size() != 0) ? wdata_q.pop_front() : 8'($urandom);
      a = base + 4'(i);
      ref_mem[a] = d;
      wq.push_back({a, d});
      bus.s_data = d; bus.s_valid = 1'b1;
      if (poke && i == 0) begin bus.start_rd = 1'b1; bus.burst_len = 5'd4; end
      @(posedge clk); #1;
      bus.s_valid = 1'b0; bus.start_rd = 1'b0; bus.s_data = 8'($urandom);
    end
    wait_done("wr_done");
  endtask

  task automatic do_read(input logic [3:0] base, input logic [4:0] len, input bit poke);
    int n;
    int w;
    @(posedge clk); #1;
    bus.start_rd = 1'b1; bus.base_addr = base; bus.burst_len = len;
    @(posedge clk); #1;
    bus.start_rd = 1'b0;
    bus.base_addr = 4'($urandom); bus.burst_len = 5'($urandom);
    chk("rd_entered", {bus.busy, bus.s_ready}, 2'b10);
    exp_done++;
    for (int i = 0; i < int'(len); i++) rq.push_back(ref_mem[base + 4'(i)]);
    if (poke) begin
      bus.start_wr = 1'b1; bus.burst_len = 5'd3;
      @(posedge clk); #1;
      bus.start_wr = 1'b0;
    end
    if (rdy_mode == 1 && !poke) begin
      w = 0;
      while (!bus.m_valid && w < 5) begin @(negedge clk); w++; end
      n = 0;
      while (bus.m_valid && bus.m_ready && n < 40) begin @(negedge clk); n++; end
      chk("rd_throughput", n, 32'(len));
    end
    wait_done("rd_done");
  endtask

  task automatic bad_start(input logic [4:0] len);
    @(posedge clk); #1;
    bus.start_wr = 1'($urandom_range(0, 1));
    bus.start_rd = ~bus.start_wr | 1'($urandom_range(0, 1));
    bus.burst_len = len;
    @(posedge clk); #1;
    bus.start_wr = 1'b0; bus.start_rd = 1'b0;
    @(negedge clk);
    chk("bad_len_idle", {bus.busy, bus.s_ready}, 0);
    @(posedge clk); @(negedge clk);
    chk("bad_len_nodone", {bus.busy, bus.done}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);
    rst_n = 1'b0;
    bus.start_wr = 1'b0; bus.start_rd = 1'b0;
    bus.base_addr = '0; bus.burst_len = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {bus.busy, bus.s_ready, bus.m_valid, bus.done, bus.ram_wr_en}, 0);
    chk("reset_mdata", 32'(bus.m_data), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ram_init = 1'b0;

    // Gapped write then stalled read-back
    wdata_q.push_back(8'hAA); wdata_q.push_back(8'h55);
    do_write(4'd3, 5'd2, 3, 1'b0, 1'b0);
    rdy_mode = 2;
    do_read(4'd3, 5'd2, 1'b0);

    // Wrap across the top of the address space
    for (int i = 1; i <= 4; i++) wdata_q.push_back(8'(i));
    do_write(4'd14, 5'd4, 0, 1'b0, 1'b0);
    rdy_mode = 0;
    do_read(4'd14, 5'd4, 1'b0);

    // Full-depth burst at one beat per cycle
    for (int i = 0; i < DEPTH; i++) wdata_q.push_back(8'(i) ^ 8'hA5);
    do_write(4'd0, 5'd16, 0, 1'b0, 1'b0);
    rdy_mode = 1;
    do_read(4'd0, 5'd16, 1'b0);

    // Simultaneous starts, illegal lengths, starts while busy
    do_write(4'd5, 5'd3, 0, 1'b1, 1'b0);
    bad_start(5'd0);
    bad_start(5'd17);
    bad_start(5'd31);
    do_write(4'd9, 5'd3, 1, 1'b0, 1'b1);
    rdy_mode = 0;
    do_read(4'd9, 5'd3, 1'b1);

    // Reset after 2 of 5 write beats
    @(posedge clk); #1;
    bus.start_wr = 1'b1; bus.base_addr = 4'd8; bus.burst_len = 5'd5;
    @(posedge clk); #1;
    bus.start_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom);
      ref_mem[4'd8 + 4'(i)] = d;
      wq.push_back({4'd8 + 4'(i), d});
      bus.s_data = d; bus.s_valid = 1'b1;
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_outs", {bus.busy, bus.s_ready, bus.done, bus.m_valid, bus.ram_wr_en}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(4'd8, 5'd2, 1'b0);

    // Randomized traffic
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write(4'($urandom), 5'($urandom_range(1, 16)), -1,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        rdy_mode = int'($urandom_range(0, 1));
        do_read(4'($urandom), 5'($urandom_range(1, 16)), 1'($urandom_range(0, 1)));
      end
    end

    repeat (5) @(posedge clk);
    chk("wq_empty", 32'(wq.size()), 0);
    chk("rq_empty", 32'(rq.size()), 0);
    chk("done_count", 32'(done_seen), 32'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
